// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: single-clock FIFO on a behavioural RAM, two-port or single-port with staging.
// Define SYNC_FIFO_ERR_FLAG_EN to add sticky ovf/udf error flags.
module sync_fifo_ram #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 15,
    parameter bit TWO_PORT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr,
    input  logic [WIDTH-1:0]       din,
    input  logic                   rd,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] used_cnt,
    output logic                   empty,
    output logic                   full
`ifdef SYNC_FIFO_ERR_FLAG_EN
    ,
    output logic                   ovf,
    output logic                   udf
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    used_q, used_d;
    logic [WIDTH-1:0] dout_q, dout_d, head;
    logic             wr_acc, rd_acc;

    assign empty    = used_q == '0;
    assign full     = used_q == CW'(DEPTH);
    assign used_cnt = used_q;
    assign dout     = dout_q;

    always_comb begin
        wr_acc = wr && !full;
        rd_acc = rd && !empty;
        used_d = (wr_acc && !rd_acc) ? used_q + CW'(1) :
                 (rd_acc && !wr_acc) ? used_q - CW'(1) : used_q;
        dout_d = rd_acc ? head : dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q <= '0;
            dout_q <= '0;
        end else begin
            used_q <= used_d;
            dout_q <= dout_d;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAG_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q || (wr && full);
        udf_d = udf_q || (rd && empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

    if (TWO_PORT) begin : g_tp
        localparam int PW = $clog2(DEPTH);

        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;

        assign head = mem[rp_q];

        always_comb begin
            wp_d = wr_acc ? ((wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1)) : wp_q;
            rp_d = rd_acc ? ((rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1)) : rp_q;
        end

        always_ff @(posedge clk) begin
            if (wr_acc)
                mem[wp_q] <= din;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp_q <= '0;
                rp_q <= '0;
            end else begin
                wp_q <= wp_d;
                rp_q <= rp_d;
            end
        end
    end else begin : g_sp
        // Order of contents is head queue, then RAM pairs, then tail queue. The RAM is
        // two words wide so one access per cycle sustains one push plus one pop per cycle.
        localparam int HN = 4;
        localparam int TN = 4;
        localparam int PD = (DEPTH + 1) / 2;
        localparam int PW = PD > 1 ? $clog2(PD) : 1;
        localparam int MW = $clog2(PD + 1);

        logic [2*WIDTH-1:0] mem [PD];
        logic [2*WIDTH-1:0] rdata, wdata;
        logic [WIDTH-1:0]   h_q [HN], h_d [HN], t_q [TN], t_d [TN];
        logic [2:0]         hc_q, hc_d, tc_q, tc_d;
        logic [MW-1:0]      mc_q, mc_d;
        logic [PW-1:0]      wp_q, wp_d, rp_q, rp_d, addr;
        logic               ram_rd, we;
        int                 hc, tc, mc;

        // Refill the head as soon as two slots are free after this cycle's pop.
        assign ram_rd = (mc_q != '0) && (int'(hc_q) - int'(rd_acc) <= HN - 2);
        assign addr   = ram_rd ? rp_q : wp_q;
        assign rdata  = mem[addr];
        assign head   = h_q[0];

        always_comb begin
            h_d   = h_q;
            t_d   = t_q;
            hc    = int'(hc_q);
            tc    = int'(tc_q);
            mc    = int'(mc_q);
            wp_d  = wp_q;
            rp_d  = rp_q;
            we    = 1'b0;
            wdata = '0;
            if (rd_acc) begin
                for (int i = 0; i < HN - 1; i++)
                    h_d[i] = h_d[i + 1];
                hc = hc - 1;
            end
            if (mc == 0) begin
                for (int k = 0; k < TN; k++) begin
                    if (hc < HN && tc > 0) begin
                        for (int i = 0; i < HN; i++)
                            if (i == hc) h_d[i] = t_d[0];
                        for (int i = 0; i < TN - 1; i++)
                            t_d[i] = t_d[i + 1];
                        hc = hc + 1;
                        tc = tc - 1;
                    end
                end
            end
            if (ram_rd) begin
                for (int i = 0; i < HN; i++) begin
                    if (i == hc) h_d[i] = rdata[WIDTH-1:0];
                    if (i == hc + 1) h_d[i] = rdata[2*WIDTH-1:WIDTH];
                end
                hc   = hc + 2;
                mc   = mc - 1;
                rp_d = (rp_q == PW'(PD - 1)) ? '0 : rp_q + PW'(1);
            end else if (tc >= 2 && mc < PD) begin
                we    = 1'b1;
                wdata = {t_d[1], t_d[0]};
                for (int i = 0; i < TN - 2; i++)
                    t_d[i] = t_d[i + 2];
                tc   = tc - 2;
                mc   = mc + 1;
                wp_d = (wp_q == PW'(PD - 1)) ? '0 : wp_q + PW'(1);
            end
            if (wr_acc) begin
                if (mc == 0 && tc == 0 && hc < HN) begin
                    for (int i = 0; i < HN; i++)
                        if (i == hc) h_d[i] = din;
                    hc = hc + 1;
                end else begin
                    for (int i = 0; i < TN; i++)
                        if (i == tc) t_d[i] = din;
                    tc = tc + 1;
                end
            end
            hc_d = 3'(hc);
            tc_d = 3'(tc);
            mc_d = MW'(mc);
        end

        always_ff @(posedge clk) begin
            if (we)
                mem[addr] <= wdata;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < HN; i++)
                    h_q[i] <= '0;
                for (int i = 0; i < TN; i++)
                    t_q[i] <= '0;
                hc_q <= '0;
                tc_q <= '0;
                mc_q <= '0;
                wp_q <= '0;
                rp_q <= '0;
            end else begin
                h_q  <= h_d;
                t_q  <= t_d;
                hc_q <= hc_d;
                tc_q <= tc_d;
                mc_q <= mc_d;
                wp_q <= wp_d;
                rp_q <= rp_d;
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_ram.sv
// tb_sync_fifo_ram: directed and random checks of both storage builds side by side against a queue model.
module tb_sync_fifo_ram;
    localparam int W  = 32;
    localparam int D  = 15;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  dout_a, dout_b;
    logic [CW-1:0] used_a, used_b;
    logic          empty_a, full_a, empty_b, full_b;
`ifdef SYNC_FIFO_ERR_FLAG_EN
    logic          ovf_a, udf_a, ovf_b, udf_b;
`endif

    always #5 clk = ~clk;

    sync_fifo_ram #(.WIDTH(W), .DEPTH(D), .TWO_PORT(1'b1)) dut_tp (
        .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .rd(rd),
        .dout(dout_a), .used_cnt(used_a), .empty(empty_a), .full(full_a)
`ifdef SYNC_FIFO_ERR_FLAG_EN
        , .ovf(ovf_a), .udf(udf_a)
`endif
    );

    sync_fifo_ram #(.WIDTH(W), .DEPTH(D), .TWO_PORT(1'b0)) dut_sp (
        .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .rd(rd),
        .dout(dout_b), .used_cnt(used_b), .empty(empty_b), .full(full_b)
`ifdef SYNC_FIFO_ERR_FLAG_EN
        , .ovf(ovf_b), .udf(udf_b)
`endif
    );

    int           n_chk = 0;
    int           n_pass = 0;
    logic [W-1:0] q [$];
    logic [W-1:0] exp_dout = '0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("used_tp", 32'(used_a), 32'(q.size()));
        chk("used_sp", 32'(used_b), 32'(q.size()));
        chk("empty_tp", 32'(empty_a), 32'(q.size() == 0));
        chk("empty_sp", 32'(empty_b), 32'(q.size() == 0));
        chk("full_tp", 32'(full_a), 32'(q.size() == D));
        chk("full_sp", 32'(full_b), 32'(q.size() == D));
        chk("dout_tp", dout_a, exp_dout);
        chk("dout_sp", dout_b, exp_dout);
    endtask

    task automatic step(input logic w, input logic r, input logic [W-1:0] d);
        bit wa, ra;
        wr = w;
        rd = r;
        din = d;
        wa = w && q.size() < D;
        ra = r && q.size() != 0;
        @(posedge clk);
        #1;
        if (ra) exp_dout = q.pop_front();
        if (wa) q.push_back(d);
        wr = 1'b0;
        rd = 1'b0;
        check_all();
    endtask

    initial begin
        #2;
        check_all();
        #10 rst_n = 1'b1;

        for (int i = 1; i <= 15; i++) step(1'b1, 1'b0, W'(i));
        chk("fill_used", 32'(used_a), 32'd15);
        chk("fill_full", 32'(full_b), 32'd1);
        step(1'b1, 1'b0, 32'h10);
        chk("wr_when_full", 32'(used_b), 32'd15);
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 1'b1, '0);
            chk("drain_tp", dout_a, W'(i));
            chk("drain_sp", dout_b, W'(i));
        end
        chk("drain_empty", 32'(empty_b), 32'd1);
        step(1'b0, 1'b1, '0);
        chk("rd_when_empty", dout_b, 32'hF);
        step(1'b1, 1'b1, 32'h77);
        chk("wr_rd_empty_used", 32'(used_b), 32'd1);
        chk("wr_rd_empty_dout", dout_a, 32'hF);
        step(1'b0, 1'b1, '0);
        chk("after_empty_wr", dout_b, 32'h77);

        for (int i = 1; i <= 15; i++) step(1'b1, 1'b0, W'(32'h100 + i));
        step(1'b1, 1'b1, 32'hBAD);
        chk("wr_rd_full_used", 32'(used_b), 32'd14);
        chk("wr_rd_full_dout", dout_b, 32'h101);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, '0);
        chk("wr_rd_full_last", dout_a, 32'h10F);

        // Steady one-in/one-out stream at occupancy 3.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(32'h200 + i));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, W'(32'h203 + i));
            chk("stream_used", 32'(used_b), 32'd3);
            chk("stream_dout", dout_b, W'(32'h200 + i));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);

        for (int i = 0; i < 40; i++) step(1'b1 && (i % 5 != 4), (i % 5 != 0), W'(32'h300 + i));
        while (q.size() != 0) step(1'b0, 1'b1, '0);

        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, W'(32'h400 + i));
        chk("pre_reset_used", 32'(used_a), 32'd7);
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_dout = '0;
        check_all();
        #1 rst_n = 1'b1;
        step(1'b1, 1'b0, 32'hDEADBEEF);
        step(1'b0, 1'b1, '0);
        chk("post_reset_tp", dout_a, 32'hDEADBEEF);
        chk("post_reset_sp", dout_b, 32'hDEADBEEF);

        for (int n = 0; n < 20000; n++) begin
            int thr_w, thr_r;
            thr_w = ((n / 300) % 3 == 0) ? 3 : ((n / 300) % 3 == 1) ? 1 : 2;
            thr_r = 4 - thr_w;
            step(($urandom_range(0, 3) < thr_w) && (q.size() < D),
                 ($urandom_range(0, 3) < thr_r) && (q.size() != 0), W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
